// File: rtl/icb_mem_responder.sv
// icb_mem_responder: ICB slave memory target at BASE_ADDR.
// Single command channel, word-organised flop-array memory, in-order
// response FIFO of RSP_DEPTH entries (which bounds outstanding transactions).
// Optional feature macro: ICB_MEM_RESPONDER_ERR_EN enables address range and
// alignment checking; without it icb_rsp_err is 0 and addresses alias.
module icb_mem_responder #(
  parameter int          DATA_WIDTH = 32,
  parameter int          MEM_DEPTH  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h10040000,
  parameter int          RSP_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      icb_cmd_valid,
  output logic                      icb_cmd_ready,
  input  logic                      icb_cmd_read,
  input  logic [31:0]               icb_cmd_addr,
  input  logic [DATA_WIDTH-1:0]     icb_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   icb_cmd_wmask,
  output logic                      icb_rsp_valid,
  input  logic                      icb_rsp_ready,
  output logic [DATA_WIDTH-1:0]     icb_rsp_rdata,
  output logic                      icb_rsp_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [DATA_WIDTH-1:0] rsp_rdata_q [RSP_DEPTH];
  logic                  rsp_err_q   [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [31:0]           offset_w;
  logic [31:0]           word_off_w;
  logic [IDX_W-1:0]      idx_w;
  logic                  addr_err_w;
  logic                  cmd_hs_w;
  logic                  rsp_hs_w;
  logic [DATA_WIDTH-1:0] push_rdata_w;
  logic                  unused_offset_bits;

  assign offset_w   = icb_cmd_addr - BASE_ADDR;
  assign word_off_w = offset_w >> LSB;
  assign idx_w      = word_off_w[IDX_W-1:0];
  // Upper offset bits only matter when range checking is compiled in.
  assign unused_offset_bits = ^word_off_w;

`ifdef ICB_MEM_RESPONDER_ERR_EN
  localparam logic [32:0] MEM_BYTES = 33'(longint'(MEM_DEPTH) * longint'(BYTES));
  // Out-of-window (including below BASE_ADDR, which wraps high) or misaligned.
  assign addr_err_w = ({1'b0, offset_w} >= MEM_BYTES) ||
                      ((offset_w & 32'(BYTES - 1)) != 32'd0);
`else
  assign addr_err_w = 1'b0;
`endif

  assign icb_cmd_ready = (cnt_q != CNT_W'(RSP_DEPTH));
  assign icb_rsp_valid = (cnt_q != '0);
  assign cmd_hs_w      = icb_cmd_valid & icb_cmd_ready;
  assign rsp_hs_w      = icb_rsp_valid & icb_rsp_ready;

  // Head entry is masked while empty so idle outputs read as zero.
  assign icb_rsp_rdata = icb_rsp_valid ? rsp_rdata_q[rd_ptr_q] : '0;
  assign icb_rsp_err   = icb_rsp_valid ? rsp_err_q[rd_ptr_q]   : 1'b0;

  // Combinational read of the addressed word; writes and errors return zero.
  always_comb begin
    push_rdata_w = '0;
    if (icb_cmd_read && !addr_err_w) push_rdata_w = mem_q[idx_w];
  end

  // Byte-lane masked memory write; array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (cmd_hs_w && !icb_cmd_read && !addr_err_w) begin
      for (int i = 0; i < BYTES; i++) begin
        if (icb_cmd_wmask[i]) mem_q[idx_w][i*8 +: 8] <= icb_cmd_wdata[i*8 +: 8];
      end
    end
  end

  // Response FIFO payload; validity is tracked by cnt_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (cmd_hs_w) begin
      rsp_rdata_q[wr_ptr_q] <= push_rdata_w;
      rsp_err_q[wr_ptr_q]   <= addr_err_w;
    end
  end

  // Next-state for pointers (wrapping modulo RSP_DEPTH) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (cmd_hs_w) wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rsp_hs_w) rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({cmd_hs_w, rsp_hs_w})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control registers; reset discards all queued responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_icb_mem_responder.sv
// Scoreboard bench for icb_mem_responder with default parameters.
module tb_icb_mem_responder;

  localparam logic [31:0] BASE = 32'h10040000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [31:0] icb_rsp_rdata;

  int checks   = 0;
  int failures = 0;

  logic [32:0] sb_q[$];        // {err, rdata}
  logic [31:0] mdl_mem[int];

  icb_mem_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic mdl_err(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
`ifdef ICB_MEM_RESPONDER_ERR_EN
    return (addr < BASE) || (off >= 32'd4096) || (addr[1:0] != 2'b00);
`else
    return (off == 32'hFFFF_FFFF) & 1'b0;
`endif
  endfunction

  function automatic int mdl_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'((off >> 2) & 32'd1023);
  endfunction

  // Monitor: handshakes seen at the negedge complete on the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (icb_rsp_valid && icb_rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          logic [32:0] e;
          e = sb_q.pop_front();
          check("rsp_rdata", {32'd0, icb_rsp_rdata}, {32'd0, e[31:0]});
          check("rsp_err", {63'd0, icb_rsp_err}, {63'd0, e[32]});
        end
      end
      if (icb_cmd_valid && icb_cmd_ready) begin
        int   idx;
        logic er;
        logic [31:0] d;
        idx = mdl_idx(icb_cmd_addr);
        er  = mdl_err(icb_cmd_addr);
        if (icb_cmd_read) begin
          d = (er || !mdl_mem.exists(idx)) ? 32'd0 : mdl_mem[idx];
          sb_q.push_back({er, d});
        end else begin
          if (!er) begin
            d = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'd0;
            for (int i = 0; i < 4; i++)
              if (icb_cmd_wmask[i]) d[i*8 +: 8] = icb_cmd_wdata[i*8 +: 8];
            mdl_mem[idx] = d;
          end
          sb_q.push_back({er, 32'd0});
        end
      end
    end
  end

  task automatic send(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] wm);
    int n;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = addr;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    n = 0;
    @(negedge clk);
    while (!icb_cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("cmd_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1 icb_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    while (icb_rsp_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain_done", {63'd0, icb_rsp_valid}, 64'd0);
  endtask

  initial begin
    int k;
    int cyc;
    rst_n = 1'b0;
    icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", {63'd0, icb_cmd_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, icb_rsp_rdata}, 64'd0);
    check("rst_rsp_err",   {63'd0, icb_rsp_err},   64'd0);
    @(posedge clk); #1;

    // Full write then back-to-back read; read response appears next cycle.
    send(1'b0, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
    send(1'b1, BASE + 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    check("raw_lat_valid", {63'd0, icb_rsp_valid}, 64'd1);
    check("raw_lat_rdata", {32'd0, icb_rsp_rdata}, {32'd0, 32'hDEADBEEF});
    drain();

    // Partial byte write merges with existing word.
    send(1'b0, BASE + 32'h10, 32'h000000AA, 4'b0001);
    send(1'b1, BASE + 32'h10, 32'h0, 4'h0);
    drain();
    check("partial_model", {32'd0, mdl_mem[4]}, {32'd0, 32'hDEADBEAA});

    // Populate six words, then back-pressure reads of them.
    for (int i = 0; i < 6; i++)
      send(1'b0, BASE + 32'h100 + 32'(i * 4), 32'hA5000000 + 32'(i * 32'h1111), 4'hF);
    drain();
    @(posedge clk); #1;
    icb_rsp_ready = 1'b0;
    k = 0;
    for (cyc = 0; cyc < 10; cyc++) begin
      icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1;
      icb_cmd_addr  = BASE + 32'h100 + 32'(k * 4);
      @(negedge clk);
      if (icb_cmd_ready) k++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_accepted", 64'(k), 64'd4);
    check("bp_cmd_ready_low", {63'd0, icb_cmd_ready}, 64'd0);
    check("bp_rsp_valid", {63'd0, icb_rsp_valid}, 64'd1);
    @(posedge clk); #1;
    icb_rsp_ready = 1'b1;
    cyc = 0;
    while (k < 6 && cyc < 50) begin
      icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1;
      icb_cmd_addr  = BASE + 32'h100 + 32'(k * 4);
      @(negedge clk);
      if (icb_cmd_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    icb_cmd_valid = 1'b0;
    check("bp_all_accepted", 64'(k), 64'd6);
    drain();

`ifdef ICB_MEM_RESPONDER_ERR_EN
    send(1'b0, BASE, 32'h12345678, 4'hF);
    send(1'b1, BASE + 32'h1000, 32'h0, 4'h0);
    send(1'b0, BASE + 32'h2, 32'hFFFFFFFF, 4'hF);
    send(1'b1, BASE, 32'h0, 4'h0);
    drain();
`endif

    // Async reset with three responses queued.
    @(posedge clk); #1;
    icb_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, BASE + 32'h200 + 32'(i * 4), 32'h0, 4'hF);
    @(negedge clk);
    check("pre_rst_valid", {63'd0, icb_rsp_valid}, 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, icb_rsp_valid}, 64'd0);
    check("mid_rst_ready", {63'd0, icb_cmd_ready}, 64'd1);
    sb_q.delete();
    mdl_mem.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    icb_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", {63'd0, icb_rsp_valid}, 64'd0);
    end
    send(1'b0, BASE + 32'h40, 32'hCAFEF00D, 4'hF);
    send(1'b1, BASE + 32'h40, 32'h0, 4'h0);
    drain();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
